// File: rtl/rr_arbiter4.sv
// rr_arbiter4 -- four-way round-robin arbiter for one shared downstream resource.
//
// Grants one requester at a time. A grant lasts while the owner keeps
// requesting, up to MAX_HOLD cycles. Two consecutive grants are always
// separated by one all-zero cycle, so the shared resource never sees two
// owners in adjacent cycles.
//
// Parameters
//   MAX_HOLD : maximum consecutive cycles one grant may stay high (1..255)
//
// Ports
//   clk     in   1  rising-edge clock
//   rst     in   1  synchronous active-high reset
//   req     in   4  request vector, bit i = requester i wants the resource
//   gnt     out  4  one-hot grant, zero when there is no owner
//   gnt_id  out  2  encoded owner index, 0 when gnt is zero
//   busy    out  1  high whenever gnt is non-zero
//   timeout out  1  one-cycle pulse in the gap that follows a grant ended
//                   by the hold limit
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Counter value reached in the last permitted grant cycle.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state_reg, state_next;
  logic [1:0] ptr_reg, ptr_next;      // index of the most recent owner
  logic [7:0] cnt_reg, cnt_next;      // cycles of current grant minus one
  logic [3:0] gnt_reg, gnt_next;
  logic [1:0] gnt_id_reg, gnt_id_next;
  logic       busy_reg, busy_next;
  logic       timeout_reg, timeout_next;

  // Candidate gi is the requester gi+1 places after the last owner, so
  // candidate 0 has the highest priority this cycle.
  logic [1:0] cand_id [4];
  logic [3:0] cand_hit;

  for (genvar gi = 0; gi < 4; gi++) begin : g_cand
    assign cand_id[gi]  = ptr_reg + 2'(gi + 1);
    assign cand_hit[gi] = req[cand_id[gi]];
  end

  logic [1:0] win_id;
  logic [3:0] win_onehot;

  always_comb begin
    win_id = cand_id[0];
    // Walk from lowest to highest priority so the highest-priority hit
    // is the last assignment.
    for (int i = 3; i >= 0; i--) begin
      if (cand_hit[i]) begin
        win_id = cand_id[i];
      end
    end
    win_onehot = 4'b0001 << win_id;
  end

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    cnt_next     = cnt_reg;
    gnt_next     = gnt_reg;
    gnt_id_next  = gnt_id_reg;
    busy_next    = busy_reg;
    timeout_next = 1'b0;

    case (state_reg)
      IDLE, GAP: begin
        gnt_next    = 4'b0000;
        gnt_id_next = 2'd0;
        busy_next   = 1'b0;
        cnt_next    = 8'd0;
        if (|req) begin
          state_next  = GRANT;
          ptr_next    = win_id;
          gnt_next    = win_onehot;
          gnt_id_next = win_id;
          busy_next   = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end

      GRANT: begin
        // A request drop wins over the hold limit, so no timeout is
        // reported when both happen in the same cycle.
        if (!req[gnt_id_reg] || (cnt_reg == HOLD_LAST)) begin
          state_next   = GAP;
          gnt_next     = 4'b0000;
          gnt_id_next  = 2'd0;
          busy_next    = 1'b0;
          cnt_next     = 8'd0;
          timeout_next = req[gnt_id_reg];
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      default: begin
        state_next  = IDLE;
        gnt_next    = 4'b0000;
        gnt_id_next = 2'd0;
        busy_next   = 1'b0;
        cnt_next    = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      ptr_reg     <= 2'd3;
      cnt_reg     <= 8'd0;
      gnt_reg     <= 4'b0000;
      gnt_id_reg  <= 2'd0;
      busy_reg    <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      cnt_reg     <= cnt_next;
      gnt_reg     <= gnt_next;
      gnt_id_reg  <= gnt_id_next;
      busy_reg    <= busy_next;
      timeout_reg <= timeout_next;
    end
  end

  assign gnt     = gnt_reg;
  assign gnt_id  = gnt_id_reg;
  assign busy    = busy_reg;
  assign timeout = timeout_reg;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4. Two instances share clock and reset:
// u_dut8 (MAX_HOLD=8) and u_dut2 (MAX_HOLD=2). Each step drives one
// request vector, queues the outputs expected after the next edge, and
// checks them one time unit after that edge.
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req8, req2;
  logic [3:0] gnt8, gnt2;
  logic [1:0] id8, id2;
  logic       busy8, busy2;
  logic       to8, to2;

  always #5 clk = ~clk;

  rr_arbiter4 #(.MAX_HOLD(8)) u_dut8 (
    .clk     (clk),
    .rst     (rst),
    .req     (req8),
    .gnt     (gnt8),
    .gnt_id  (id8),
    .busy    (busy8),
    .timeout (to8)
  );

  rr_arbiter4 #(.MAX_HOLD(2)) u_dut2 (
    .clk     (clk),
    .rst     (rst),
    .req     (req2),
    .gnt     (gnt2),
    .gnt_id  (id2),
    .busy    (busy2),
    .timeout (to2)
  );

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] v;   // {gnt, gnt_id, busy, timeout}
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // sel 0 drives/checks u_dut8, sel 1 drives/checks u_dut2; the other
  // instance sees no requests.
  task automatic step(input string tag, input int sel, input logic r_rst,
                      input logic [3:0] r, input logic [3:0] eg,
                      input logic [1:0] eid, input logic eb, input logic eto);
    exp_t       e;
    logic [7:0] obs;
    rst = r_rst;
    if (sel == 0) begin
      req8 = r;
      req2 = 4'b0000;
    end else begin
      req2 = r;
      req8 = 4'b0000;
    end
    e.tag = tag;
    e.sel = sel;
    e.v   = {eg, eid, eb, eto};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e   = sb.pop_front();
    obs = (e.sel == 0) ? {gnt8, id8, busy8, to8} : {gnt2, id2, busy2, to2};
    n_vec++;
    $display("[%0t] %s dut%0d rst=%b req=%b -> gnt=%b id=%0d busy=%b timeout=%b",
             $time, e.tag, (e.sel == 0) ? 8 : 2, r_rst, r,
             obs[7:4], obs[3:2], obs[1], obs[0]);
    assert (obs === e.v) else begin
      n_err++;
      $error("FAIL %s: observed gnt/id/busy/timeout=%b_%b_%b_%b required=%b_%b_%b_%b",
             e.tag, obs[7:4], obs[3:2], obs[1], obs[0],
             e.v[7:4], e.v[3:2], e.v[1], e.v[0]);
    end
  endtask

  initial begin
    rst  = 1'b1;
    req8 = 4'b0000;
    req2 = 4'b0000;

    // Reset held two cycles with all requesting, then first grant to 0.
    step("rst_a",      0, 1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0);
    step("rst_b",      0, 1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0);
    step("first_gnt",  0, 1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("first_rel",  0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step("first_idle", 0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single short request for three cycles.
    for (int i = 0; i < 3; i++)
      step("short_gnt", 0, 1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    step("short_gap",  0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step("short_idle", 0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Priority rotation: after owner 2, 0101 goes to 0, then to 2.
    step("rot_g2",     0, 1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    step("rot_gap_a",  0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step("rot_g0",     0, 1'b0, 4'b0101, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("rot_gap_b",  0, 1'b0, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0);
    step("rot_g2b",    0, 1'b0, 4'b0101, 4'b0100, 2'd2, 1'b1, 1'b0);
    step("rot_gap_c",  0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step("rot_idle",   0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Hold limit: continuous request from 1 is cut after 8 cycles, then
    // re-granted after one gap since it is the only requester.
    for (int i = 0; i < 8; i++)
      step("hold_gnt_a", 0, 1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    step("hold_to_a",  0, 1'b0, 4'b0010, 4'b0000, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++)
      step("hold_gnt_b", 0, 1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    step("hold_to_b",  0, 1'b0, 4'b0010, 4'b0000, 2'd0, 1'b0, 1'b1);
    step("hold_idle",  0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Owner drops its request on the cycle the hold limit is reached.
    for (int i = 0; i < 8; i++)
      step("corner_gnt", 0, 1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    step("corner_drop", 0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step("corner_idle", 0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Reset in the middle of a grant to 3; pointer returns to 3.
    step("mid_g3_a",   0, 1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
    step("mid_g3_b",   0, 1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
    step("mid_rst",    0, 1'b1, 4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step("mid_g0",     0, 1'b0, 4'b1001, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("mid_gap",    0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step("mid_idle",   0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Fairness with MAX_HOLD=2 and all four requesting.
    for (int k = 0; k < 4; k++) begin
      step("rr_gnt_a", 1, 1'b0, 4'b1111, 4'(1 << k), 2'(k), 1'b1, 1'b0);
      step("rr_gnt_b", 1, 1'b0, 4'b1111, 4'(1 << k), 2'(k), 1'b1, 1'b0);
      step("rr_gap",   1, 1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b1);
    end
    step("rr_wrap",    1, 1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("rr_drop",    1, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step("rr_idle",    1, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Round-robin arbiter that shares one downstream resource (e.g. a 4-to-2 encoded select path) among four requesters. It samples a 4-bit request vector, issues a one-hot grant plus its 2-bit encoded index, holds the grant while the owner keeps requesting, and forces a release after a programmable hold limit. A one-cycle dead gap separates consecutive grants so the shared resource never sees two owners in adjacent cycles.

## Interface
- MAX_HOLD, 8, maximum consecutive cycles one grant may stay asserted; legal range 1..255
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  4  request vector; bit i high = requester i wants the resource
- gnt  output  4  one-hot grant; all-zero when no owner
- gnt_id  output  2  encoded index of the owner (0..3); 2'b00 when gnt is zero
- busy  output  1  high whenever gnt is non-zero
- timeout  output  1  one-cycle pulse when a grant is ended by the hold limit

## Operation
- All outputs are registered. Reset values: gnt=4'b0000, gnt_id=2'b00, busy=0, timeout=0; internal state=IDLE, last-owner pointer=3, hold counter=0.
- States: IDLE, GRANT, GAP.
- IDLE: if req!=0, at the next edge select winner, go to GRANT, load gnt/gnt_id, clear counter; else stay.
- Winner selection: scan req starting at (last+1) mod 4, wrapping upward; first set bit wins. Winner becomes new pointer value at the grant edge. Pointer reset value 3 gives priority order 0,1,2,3 after reset.
- GRANT: counter increments every cycle; counter value k means gnt has been high for k+1 cycles.
  - If req[owner]==0: next edge -> GAP, timeout stays 0.
  - Else if counter==MAX_HOLD-1: next edge -> GAP, timeout=1 for that one cycle.
  - Else stay in GRANT.
  - Simultaneous req drop and hold limit: treated as req drop (no timeout).
  - Changes on non-owner req bits never affect the current grant.
- GAP: gnt=0, gnt_id=0, busy=0 for exactly one cycle. At its end edge: if req!=0 arbitrate (same rule as IDLE) and enter GRANT; else enter IDLE.
- A timed-out requester still requesting is only re-granted when its turn returns in round-robin order (immediately if it is the only requester).
- Counter width: 8 bits; never exceeds MAX_HOLD-1.
- MAX_HOLD=1: every grant lasts exactly one cycle; timeout pulses whenever owner still requests.

## Timing
- Request-to-grant latency: 1 cycle from IDLE (req sampled high at edge N -> gnt high after edge N).
- Release latency: owner drops req before edge N -> gnt low after edge N (gnt is seen high in the cycle of the drop).
- Grant-to-grant: exactly one all-zero cycle (GAP) between any two grants, including back-to-back grants to the same requester.
- timeout coincides with the first GAP cycle.
- Reset mid-grant: asserting rst before edge N yields reset values after edge N regardless of state; pointer returns to 3.
- Throughput bound with all four requesting continuously: each requester gets MAX_HOLD cycles out of every 4*(MAX_HOLD+1).

## Test plan
- Reset: hold rst 2 cycles with req=4'b1111 -> gnt=0, gnt_id=0, busy=0, timeout=0 throughout; first grant after release is gnt=4'b0001, gnt_id=0, one cycle after rst low.
- Single short request: req=4'b0100 for 3 cycles then 0 -> gnt=4'b0100, gnt_id=2 for 3 cycles, one GAP, then IDLE; timeout never asserted.
- Hold limit (MAX_HOLD=8): req=4'b0010 held constantly -> gnt=4'b0010 for 8 cycles, timeout=1 with gnt=0 for 1 cycle, then re-grant to 1 for 8 more cycles.
- Round-robin fairness: req=4'b1111 constant, MAX_HOLD=2 -> gnt_id sequence 0,0,-,1,1,-,2,2,-,3,3,-,0... with timeout pulsing in every gap.
- Priority rotation: grant to 2 ends, req=4'b0101 in the GAP -> next owner is 0 (scan 3,0); then with req=4'b0101 again -> owner 2.
- Corner cases: owner drops req on the same cycle counter hits MAX_HOLD-1 -> GAP with timeout=0; rst asserted mid-GRANT on owner 3 -> outputs cleared next edge and next grant with req=4'b1001 goes to 0.
